// File: rtl/prior_sel_serializer.sv
// Serializes a flagged lane vector into one beat per flagged lane, in priority order,
// with an optional default lane emitted when no flag is set.
module prior_sel_serializer #(
  parameter int BIT_WIDTH          = 2,
  parameter int SEL_SIG_NUMS       = 8,
  parameter int PRIORITY_DIRECTION = 1,
  parameter int DEFAULT_INPUT_EN   = 0,
  localparam int DEF   = (DEFAULT_INPUT_EN != 0) ? 1 : 0,
  localparam int IDX_W = $clog2(SEL_SIG_NUMS + DEF),
  localparam int CNT_W = $clog2(SEL_SIG_NUMS + 1),
  localparam int DW    = BIT_WIDTH * (SEL_SIG_NUMS + DEF)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_SIG_NUMS-1:0] sel,
  input  logic [DW-1:0]           in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_idx,
  output logic [BIT_WIDTH-1:0]    out_val,
  output logic                    out_last,
  output logic                    out_dflt,
  output logic                    done,
  output logic [CNT_W-1:0]        count
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                  state_q, state_d;
  logic                    dflt_q, dflt_d;
  logic [SEL_SIG_NUMS-1:0] pend_q, pend_d;
  logic [DW-1:0]           data_q, data_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    done_q, done_d;

  logic [IDX_W-1:0] pri_idx;
  logic [IDX_W-1:0] beat_idx;
  logic             pend_one;
  logic             busy;

  // Single-pass priority encode: the last matching lane in scan order wins.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pri_idx = '0;
    if (PRIORITY_DIRECTION >= 0) begin
      for (int i = 0; i < SEL_SIG_NUMS; i++)
        if (pend_q[i]) pri_idx = IDX_W'(i);
    end else begin
      for (int i = SEL_SIG_NUMS - 1; i >= 0; i--)
        if (pend_q[i]) pri_idx = IDX_W'(i);
    end
  end

  assign pend_one = (pend_q != '0) && ((pend_q & (pend_q - SEL_SIG_NUMS'(1))) == '0);
  assign busy     = (state_q == BUSY);
  assign beat_idx = dflt_q ? IDX_W'(SEL_SIG_NUMS) : pri_idx;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = busy;
  assign out_idx   = busy ? beat_idx : '0;
  assign out_val   = busy ? data_q[beat_idx*BIT_WIDTH +: BIT_WIDTH] : '0;
  assign out_last  = busy & (dflt_q | pend_one);
  assign out_dflt  = busy & dflt_q;
  assign done      = done_q;
  assign count     = count_q;

  always_comb begin
    state_d = state_q;
    dflt_d  = dflt_q;
    pend_d  = pend_q;
    data_d  = data_q;
    count_d = count_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          pend_d  = sel;
          data_d  = in;
          count_d = '0;
          dflt_d  = 1'b0;
          if (sel != '0) begin
            state_d = BUSY;
          end else if (DEF != 0) begin
            state_d = BUSY;
            dflt_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (out_ready) begin
          pend_d = pend_q & ~(SEL_SIG_NUMS'(1) << pri_idx);
          if (!dflt_q) count_d = count_q + CNT_W'(1);
          if (out_last) begin
            state_d = IDLE;
            dflt_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dflt_q  <= 1'b0;
      pend_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dflt_q  <= dflt_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_prior_sel_serializer.sv
// Bench for prior_sel_serializer: MSB-first, LSB-first and default-lane instances run in
// lockstep on shared inputs against a beat-list reference model.
module tb_prior_sel_serializer;

  localparam int W = 2;
  localparam int N = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic [N-1:0]       sel = '0;
  logic [W*(N+1)-1:0] in_d = '0;

  always #5 clk = ~clk;

  logic       o_rdy [3];
  logic       o_vld [3];
  logic       o_last[3];
  logic       o_dflt[3];
  logic       o_done[3];
  logic [3:0] o_idx [3];
  logic [1:0] o_val [3];
  logic [3:0] o_cnt [3];
  logic [2:0] idx0, idx1;
  logic [3:0] idx2;

  assign o_idx[0] = {1'b0, idx0};
  assign o_idx[1] = {1'b0, idx1};
  assign o_idx[2] = idx2;

  prior_sel_serializer #(.BIT_WIDTH(W), .SEL_SIG_NUMS(N), .PRIORITY_DIRECTION(1), .DEFAULT_INPUT_EN(0)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[0]), .sel(sel), .in(in_d[W*N-1:0]),
    .out_valid(o_vld[0]), .out_ready(out_ready), .out_idx(idx0), .out_val(o_val[0]),
    .out_last(o_last[0]), .out_dflt(o_dflt[0]), .done(o_done[0]), .count(o_cnt[0]));

  prior_sel_serializer #(.BIT_WIDTH(W), .SEL_SIG_NUMS(N), .PRIORITY_DIRECTION(-1), .DEFAULT_INPUT_EN(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[1]), .sel(sel), .in(in_d[W*N-1:0]),
    .out_valid(o_vld[1]), .out_ready(out_ready), .out_idx(idx1), .out_val(o_val[1]),
    .out_last(o_last[1]), .out_dflt(o_dflt[1]), .done(o_done[1]), .count(o_cnt[1]));

  prior_sel_serializer #(.BIT_WIDTH(W), .SEL_SIG_NUMS(N), .PRIORITY_DIRECTION(1), .DEFAULT_INPUT_EN(1)) u_dflt (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[2]), .sel(sel), .in(in_d),
    .out_valid(o_vld[2]), .out_ready(out_ready), .out_idx(idx2), .out_val(o_val[2]),
    .out_last(o_last[2]), .out_dflt(o_dflt[2]), .done(o_done[2]), .count(o_cnt[2]));

  // Reference model: on accept, each instance gets the list of beats it must emit, in order.
  typedef struct {
    int idx;
    int val;
    bit last;
    bit dflt;
  } beat_t;

  beat_t mb[3][N+1];
  int    mhead[3];
  int    mlen[3];
  int    mcount[3];
  bit    mdone[3];
  string nm[3] = '{"msb", "lsb", "dflt"};

  int n_vec = 0;
  int n_err = 0;

  function automatic int lane(int i);
    return int'(in_d[i*W +: W]);
  endfunction

  function automatic bit mbusy(int k);
    return mhead[k] < mlen[k];
  endfunction

  function automatic bit any_busy();
    return mbusy(0) || mbusy(1) || mbusy(2);
  endfunction

  task automatic build(int k);
    mhead[k] = 0;
    mlen[k]  = 0;
    for (int j = 0; j < N; j++) begin
      int i;
      i = (k == 1) ? j : N - 1 - j;
      if (sel[i]) begin
        mb[k][mlen[k]] = '{idx: i, val: lane(i), last: 1'b0, dflt: 1'b0};
        mlen[k]++;
      end
    end
    if (mlen[k] == 0 && k == 2) begin
      mb[k][0] = '{idx: N, val: lane(N), last: 1'b0, dflt: 1'b1};
      mlen[k]  = 1;
    end
    if (mlen[k] > 0) mb[k][mlen[k]-1].last = 1'b1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mhead[k] = 0; mlen[k] = 0; mcount[k] = 0; mdone[k] = 1'b0;
    end
  endtask

  // One clock: compare at the falling edge, advance the model to its post-edge state, then
  // return just after the rising edge so callers can drive the next inputs.
  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      bit b;
      b = mbusy(k);
      n_vec++;
      if (o_vld[k] !== b) begin
        n_err++; $display("FAIL %s out_valid got %0b want %0b @%0t", nm[k], o_vld[k], b, $time);
      end
      if (o_rdy[k] !== !b) begin
        n_err++; $display("FAIL %s in_ready got %0b want %0b @%0t", nm[k], o_rdy[k], !b, $time);
      end
      if (o_done[k] !== mdone[k]) begin
        n_err++; $display("FAIL %s done got %0b want %0b @%0t", nm[k], o_done[k], mdone[k], $time);
      end
      if (o_cnt[k] !== 4'(mcount[k])) begin
        n_err++; $display("FAIL %s count got %0d want %0d @%0t", nm[k], o_cnt[k], mcount[k], $time);
      end
      if (b) begin
        beat_t e;
        e = mb[k][mhead[k]];
        if (o_idx[k] !== 4'(e.idx) || o_val[k] !== 2'(e.val) || o_last[k] !== e.last || o_dflt[k] !== e.dflt) begin
          n_err++;
          $display("FAIL %s beat got idx=%0d val=%0d last=%0b dflt=%0b want idx=%0d val=%0d last=%0b dflt=%0b @%0t",
                   nm[k], o_idx[k], o_val[k], o_last[k], o_dflt[k], e.idx, e.val, e.last, e.dflt, $time);
        end
      end
    end
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        bit nd;
        nd = 1'b0;
        if (mbusy(k)) begin
          if (out_ready) begin
            if (!mb[k][mhead[k]].dflt) mcount[k]++;
            if (mb[k][mhead[k]].last) nd = 1'b1;
            mhead[k]++;
          end
        end else if (in_valid) begin
          build(k);
          mcount[k] = 0;
          if (mlen[k] == 0) nd = 1'b1;
        end
        mdone[k] = nd;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && any_busy(); c++) cycle();
    n_vec++;
    if (any_busy()) begin
      n_err++; $display("FAIL drain_timeout still busy after 40 cycles @%0t", $time);
    end
    cycle();
  endtask

  task automatic load_test1();
    sel  = 8'b1010_0100;
    in_d = '0;
    in_d[7*W +: W] = 2'b11;
    in_d[5*W +: W] = 2'b01;
    in_d[2*W +: W] = 2'b10;
  endtask

  task automatic test_reset();
    #12;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (o_rdy[k] !== 1'b1 || o_vld[k] !== 1'b0 || o_done[k] !== 1'b0 || o_cnt[k] !== 4'd0 ||
          o_idx[k] !== 4'd0 || o_val[k] !== 2'd0 || o_last[k] !== 1'b0 || o_dflt[k] !== 1'b0) begin
        n_err++;
        $display("FAIL %s reset_state got rdy=%0b vld=%0b done=%0b cnt=%0d idx=%0d val=%0d last=%0b dflt=%0b want 1,0,0,0,0,0,0,0",
                 nm[k], o_rdy[k], o_vld[k], o_done[k], o_cnt[k], o_idx[k], o_val[k], o_last[k], o_dflt[k]);
      end
    end
    @(posedge clk); #1;
    model_reset();
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_priority();
    load_test1();
    in_valid = 1'b1;
    out_ready = 1'b1;
    cycle();
    drain();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (o_cnt[k] !== 4'd3) begin
        n_err++; $display("FAIL %s test1_count got %0d want 3", nm[k], o_cnt[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    load_test1();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cycle();
    sel = 8'hFF;
    cycle();
    out_ready = 1'b0;
    repeat (3) cycle();
    out_ready = 1'b1;
    repeat (3) cycle();
    drain();
  endtask

  task automatic test_empty();
    sel  = '0;
    in_d = '0;
    in_d[N*W +: W] = 2'b10;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cycle();
    drain();
  endtask

  task automatic test_full();
    sel = 8'hFF;
    for (int i = 0; i <= N; i++) in_d[i*W +: W] = 2'(i);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cycle();
    drain();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (o_cnt[k] !== 4'd8) begin
        n_err++; $display("FAIL %s full_count got %0d want 8", nm[k], o_cnt[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    load_test1();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (o_vld[k] !== 1'b0 || o_cnt[k] !== 4'd0 || o_done[k] !== 1'b0) begin
        n_err++;
        $display("FAIL %s reset_mid got vld=%0b cnt=%0d done=%0b want 0,0,0", nm[k], o_vld[k], o_cnt[k], o_done[k]);
      end
    end
    model_reset();
    cycle();
    rst_n = 1'b1;
    repeat (4) cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sel       = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
      in_d      = 18'($urandom);
      cycle();
    end
    drain();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_priority();
    test_backpressure();
    test_empty();
    test_full();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
